// File: rtl/servo_slew_scheduler.sv
// rtl/servo_slew_scheduler.sv - frame-synchronous per-channel servo pulse-width slew scheduler
// Optional feature macro: SERVO_SLEW_EN (slew limiting; undefined = direct target copy per sweep).
module servo_slew_scheduler #(
  parameter int CHANNELS  = 12,
  parameter int WIDTH     = 16,
  parameter int PULSE_MIN = 1000,
  parameter int PULSE_MAX = 2000,
  parameter int STEP      = 10
) (
  input  logic                      i_clock,
  input  logic                      i_reset_n,
  input  logic                      i_cmd_valid,
  output logic                      o_cmd_ready,
  input  logic [7:0]                i_cmd_index,
  input  logic [WIDTH-1:0]          i_cmd_pulse,
  input  logic                      i_frame,
  output logic [CHANNELS*WIDTH-1:0] o_pulse,
  output logic                      o_busy,
  output logic                      o_err,
  output logic                      o_overrun
);

  typedef enum logic {IDLE, SWEEP} state_e;

  localparam logic [WIDTH-1:0] P_MIN   = WIDTH'(PULSE_MIN);
  localparam logic [WIDTH-1:0] P_MAX   = WIDTH'(PULSE_MAX);
  localparam logic [WIDTH-1:0] CENTER  = WIDTH'((PULSE_MIN + PULSE_MAX) / 2);
  localparam logic [7:0]       LAST_CH = 8'(CHANNELS - 1);

  state_e           state_q, state_d;
  logic [7:0]       ch_q, ch_d;
  logic [WIDTH-1:0] tgt_q [CHANNELS];
  logic [WIDTH-1:0] tgt_d [CHANNELS];
  logic [WIDTH-1:0] cur_q [CHANNELS];
  logic [WIDTH-1:0] cur_d [CHANNELS];
  logic             err_q, err_d;
  logic             ovr_q, ovr_d;

  logic             accept;
  logic             idx_ok;
  logic [WIDTH-1:0] clamped;
  logic [WIDTH-1:0] sel_tgt;
  logic [WIDTH-1:0] sel_cur;
  logic [WIDTH-1:0] next_cur;

  assign o_cmd_ready = (state_q == IDLE);
  assign o_busy      = (state_q == SWEEP);
  assign o_err       = err_q;
  assign o_overrun   = ovr_q;
  assign accept      = i_cmd_valid && o_cmd_ready;
  assign idx_ok      = ({1'b0, i_cmd_index} < 9'(CHANNELS));

  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign o_pulse[g*WIDTH +: WIDTH] = cur_q[g];
  end

  always_comb begin
    clamped = i_cmd_pulse;
    if (i_cmd_pulse < P_MIN) clamped = P_MIN;
    else if (i_cmd_pulse > P_MAX) clamped = P_MAX;
  end

  // Single shared datapath: mux out the channel under the sweep pointer.
  always_comb begin
    sel_tgt = '0;
    sel_cur = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ch_q == 8'(k)) begin
        sel_tgt = tgt_q[k];
        sel_cur = cur_q[k];
      end
    end
  end

`ifdef SERVO_SLEW_EN
  localparam logic signed [WIDTH:0] STEP_S = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0]      P_STEP = WIDTH'(STEP);
  logic signed [WIDTH:0] diff;

  always_comb begin
    diff     = $signed({1'b0, sel_tgt}) - $signed({1'b0, sel_cur});
    next_cur = sel_tgt;
    if (diff > STEP_S) next_cur = sel_cur + P_STEP;
    else if (diff < -STEP_S) next_cur = sel_cur - P_STEP;
  end
`else
  assign next_cur = sel_tgt;
`endif

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    tgt_d   = tgt_q;
    cur_d   = cur_q;
    err_d   = 1'b0;
    ovr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // The write lands before the sweep starts, so a same-cycle command joins this sweep.
        if (accept) begin
          if (idx_ok) begin
            for (int k = 0; k < CHANNELS; k++) begin
              if (i_cmd_index == 8'(k)) tgt_d[k] = clamped;
            end
          end else begin
            err_d = 1'b1;
          end
        end
        if (i_frame) begin
          state_d = SWEEP;
          ch_d    = 8'd0;
        end
      end
      SWEEP: begin
        for (int k = 0; k < CHANNELS; k++) begin
          if (ch_q == 8'(k)) cur_d[k] = next_cur;
        end
        ovr_d = i_frame;
        if (ch_q == LAST_CH) begin
          state_d = IDLE;
          ch_d    = 8'd0;
        end else begin
          ch_d = ch_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      ch_q    <= 8'd0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        tgt_q[k] <= CENTER;
        cur_q[k] <= CENTER;
      end
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
      tgt_q   <= tgt_d;
      cur_q   <= cur_d;
    end
  end

endmodule

// File: doc/servo_slew_scheduler.md
# servo_slew_scheduler

Frame-synchronous scheduler that owns the per-channel pulse-width registers feeding the servo PWM generator bank. It accepts target pulse widths from the command side through a valid/ready handshake, then once per PWM frame sweeps all channels through one shared update datapath. The sweep moves each live pulse width toward its target by at most a fixed step, so servos cannot be slammed across their range in one frame. It sits between the SPI command decoder and the `pwm_gen` instances; its `o_pulse` slices drive each generator's `i_pulse`.

## Interface
- `CHANNELS`, 12, number of servo channels, 1..255.
- `WIDTH`, 16, pulse-width field width in PWM ticks (1 tick = 1 us).
- `PULSE_MIN`, 1000, lowest legal pulse width.
- `PULSE_MAX`, 2000, highest legal pulse width.
- `STEP`, 10, maximum change per channel per frame. Must be ≥1.
- `i_clock`  in  1  system clock; all logic on the rising edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_cmd_valid`  in  1  a command is present.
- `o_cmd_ready`  out  1  the block can accept a command this cycle.
- `i_cmd_index`  in  8  target channel number.
- `i_cmd_pulse`  in  WIDTH  requested pulse width.
- `i_frame`  in  1  one-cycle strobe at each PWM frame start.
- `o_pulse`  out  CHANNELS*WIDTH  live pulse widths; channel k occupies `[k*WIDTH +: WIDTH]`.
- `o_busy`  out  1  high while a sweep is in progress.
- `o_err`  out  1  one-cycle pulse when a command is rejected for a bad index.
- `o_overrun`  out  1  one-cycle pulse when a frame strobe is dropped.

## Operation
- **Register file:** two arrays, `tgt[CHANNELS]` and `cur[CHANNELS]`. `o_pulse` is `cur`, driven straight from registers with no combinational path from the inputs.
- **States:**
  - IDLE: `o_cmd_ready`=1, `o_busy`=0.
  - SWEEP: `o_cmd_ready`=0, `o_busy`=1, with a channel counter `ch` running 0..CHANNELS-1.
- **Command accept:** a command is accepted when `i_cmd_valid` and `o_cmd_ready` are both high at a clock edge.
  - If `i_cmd_index` < CHANNELS: `tgt[index]` ← clamp(`i_cmd_pulse`, PULSE_MIN, PULSE_MAX).
  - Otherwise: the handshake still completes, nothing is written, and `o_err` pulses for one cycle.
- **IDLE → SWEEP:** taken on `i_frame`=1, with `ch` set to 0. A command accepted in the same cycle is written first, so it takes part in this sweep.
- **Per-channel update:** each SWEEP cycle updates `cur[ch]` only.
  - d = `tgt[ch]` − `cur[ch]`, computed signed in WIDTH+1 bits.
  - If |d| ≤ STEP: `cur[ch]` ← `tgt[ch]`.
  - Else: `cur[ch]` ← `cur[ch]` ± STEP, moving toward the target.
  - `tgt` and `cur` both stay within [PULSE_MIN, PULSE_MAX], so no overflow or wrap is possible.
- **Sweep end:** when `ch` = CHANNELS-1, the block returns to IDLE after that update.
- **Dropped frame:** `i_frame` during SWEEP is dropped and `o_overrun` pulses for one cycle. It is not queued.
- **Reset:** `i_reset_n` low, at any time including mid-sweep, forces IDLE, sets every `tgt` and `cur` to CENTER = (PULSE_MIN+PULSE_MAX)/2 (1500 with the defaults), and clears `ch`, `o_err` and `o_overrun`.

## Timing
- **Reset values:**
  - `o_pulse`: CENTER on every channel.
  - `o_busy`: 0.
  - `o_cmd_ready`: 1 once reset is released.
  - `o_err`: 0.
  - `o_overrun`: 0.
- **Sweep latency:** `i_frame` is sampled at edge E0. Channel k's `cur` is updated at edge E(k+1). The block is back in IDLE after edge E(CHANNELS), with `o_busy` high from E0 to E(CHANNELS).
- **Command latency:** an accepted command writes `tgt` at the accepting edge. It first affects `cur` at the next sweep.
- **Handshake:** `o_cmd_ready` is combinational from state only and drops to 0 the cycle after E0. The master must hold `i_cmd_valid` and the data stable until it is accepted.
- **Frame spacing:** frames must be ≥ CHANNELS+1 cycles apart; a frame arriving sooner hits the dropped-frame rule.
- **Full travel time:** ceil((PULSE_MAX−PULSE_MIN)/STEP) frames for end-to-end travel; 100 frames with the defaults.

## Configuration
- Macro: `SERVO_SLEW_EN`.
- **Defined:** slew limiting as described under Operation.
- **Undefined:** each sweep cycle copies `cur[ch]` ← `tgt[ch]` directly. The subtractor and comparator are not built. All other behaviour is unchanged: states, timing, clamping, `o_err`, `o_overrun`.

## Test plan
- **Reset:** assert `i_reset_n`=0 mid-sweep, then release → all 12 `o_pulse` slices = 1500, IDLE, `o_cmd_ready`=1, `o_busy`=0.
- **Slew:** write ch3=1600, then issue 10 frames → ch3 reads 1510, 1520, … 1600 after successive sweeps, holds at 1600 on the 11th, and all other channels stay at 1500.
- **Clamping and bad index:** write ch0=500 and ch11=3000 → targets 1000 and 2000. Write index 12 → accepted, `o_err` pulses for one cycle, and no channel changes.
- **Command/frame collision:** command ch5=1505 in the same cycle as `i_frame` → ch5=1505 at E6; `o_cmd_ready`=0 for cycles E1–E12.
- **Overrun:** `i_frame` at E0 and again at E5 → `o_overrun` pulses once, exactly one sweep occurs, and `o_busy` falls after E12.
- **Macro off:** rebuild without `SERVO_SLEW_EN`, write ch7=2000, issue 1 frame → ch7=2000 at E8.
